// File: rtl/fft_exp_tagger_512mmax_pkg.sv
// Shared tuser layout for the exponent tagger and the downstream exponent shifter.
package fft_exp_tagger_512mmax_pkg;

   localparam int MAX_FFT = 512;
   localparam int BIN_LSB = 0;
   localparam int BIN_W   = $clog2(MAX_FFT);
   localparam int EXP_LSB = 16;
   localparam int EXP_W   = 5;
   localparam int TUSER_W = 24;

   function automatic logic [TUSER_W-1:0] pack_tuser(input logic [EXP_W-1:0] exp_val,
                                                     input logic [BIN_W-1:0] bin_val);
      logic [TUSER_W-1:0] u;
      u = '0;
      u[EXP_LSB +: EXP_W] = exp_val;
      u[BIN_LSB +: BIN_W] = bin_val;
      return u;
   endfunction

endpackage

// File: rtl/fft_exp_tagger_512mmax_fifo.sv
// Stream FIFO on an inferred RAM with a registered first-word output stage.
module axi_fifo_51 #(
   parameter int DATA_WIDTH  = 32,
   parameter int TUSER_WIDTH = 0,
   parameter int ADDR_WIDTH  = 10
) (
   input  logic                              clk,
   input  logic                              sync_reset,
   input  logic                              s_tvalid,
   input  logic [DATA_WIDTH+TUSER_WIDTH-1:0] s_tdata,
   output logic                              s_tready,
   output logic                              m_tvalid,
   output logic [DATA_WIDTH+TUSER_WIDTH-1:0] m_tdata,
   input  logic                              m_tready
);

   localparam int W     = DATA_WIDTH + TUSER_WIDTH;
   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [W-1:0]          mem [DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [ADDR_WIDTH:0]   ram_cnt_reg;
   logic [ADDR_WIDTH:0]   level;
   logic                  out_valid_reg;
   logic [W-1:0]          out_data_reg;
   logic                  push, load;

   // Occupancy counts the output register so the FIFO holds exactly DEPTH words.
   assign level    = ram_cnt_reg + {{ADDR_WIDTH{1'b0}}, out_valid_reg};
   assign s_tready = (level != (ADDR_WIDTH+1)'(DEPTH));
   assign push     = s_tvalid & s_tready;
   assign load     = (ram_cnt_reg != '0) & (~out_valid_reg | m_tready);
   assign m_tvalid = out_valid_reg;
   assign m_tdata  = out_data_reg;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_reg] <= s_tdata;
   end

   always_ff @(posedge clk or posedge sync_reset) begin
      if (sync_reset) begin
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         ram_cnt_reg   <= '0;
         out_valid_reg <= 1'b0;
         out_data_reg  <= '0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + ADDR_WIDTH'(1);
         if (load) begin
            rd_ptr_reg    <= rd_ptr_reg + ADDR_WIDTH'(1);
            out_data_reg  <= mem[rd_ptr_reg];
            out_valid_reg <= 1'b1;
         end else if (m_tready) begin
            out_valid_reg <= 1'b0;
         end
         case ({push, load})
            2'b10:   ram_cnt_reg <= ram_cnt_reg + (ADDR_WIDTH+1)'(1);
            2'b01:   ram_cnt_reg <= ram_cnt_reg - (ADDR_WIDTH+1)'(1);
            default: ram_cnt_reg <= ram_cnt_reg;
         endcase
      end
   end

endmodule

// File: rtl/fft_exp_tagger_512mmax.sv
// Holds each FFT frame until its block exponent arrives, then emits it with bin/exponent in tuser.
module fft_exp_tagger_512mmax
   import fft_exp_tagger_512mmax_pkg::*;
#(
   parameter int DATA_AW = 10,
   parameter int EXP_AW  = 2
) (
   input  logic                clk,
   input  logic                sync_reset,
   input  logic                s_axis_tvalid,
   input  logic [31:0]         s_axis_tdata,
   input  logic                s_axis_tlast,
   output logic                s_axis_tready,
   input  logic                s_status_tvalid,
   input  logic [EXP_W-1:0]    s_status_tdata,
   output logic                s_status_tready,
   input  logic [9:0]          fft_size,
   output logic                frame_err,
   output logic                m_axis_tvalid,
   output logic [31:0]         m_axis_tdata,
   output logic [TUSER_W-1:0]  m_axis_tuser,
   output logic                m_axis_tlast,
   input  logic                m_axis_tready
);

   localparam int EXP_DEPTH = 1 << EXP_AW;

   logic             fifo_s_ready, fifo_m_valid, fifo_m_ready;
   logic             in_take, out_take, in_last;
   logic [BIN_W-1:0] in_bin_reg, out_bin_reg;
   logic [9:0]       size_reg, out_size_reg;
   logic             frame_err_reg;

   logic [EXP_W-1:0]  exp_mem_reg [EXP_DEPTH];
   logic [EXP_AW-1:0] exp_wr_ptr_reg, exp_rd_ptr_reg;
   logic [EXP_AW:0]   exp_cnt_reg;
   logic              exp_push, exp_pop, exp_nonempty;

   axi_fifo_51 #(
      .DATA_WIDTH  (32),
      .TUSER_WIDTH (0),
      .ADDR_WIDTH  (DATA_AW)
   ) u_data_fifo (
      .clk        (clk),
      .sync_reset (sync_reset),
      .s_tvalid   (s_axis_tvalid),
      .s_tdata    (s_axis_tdata),
      .s_tready   (fifo_s_ready),
      .m_tvalid   (fifo_m_valid),
      .m_tdata    (m_axis_tdata),
      .m_tready   (fifo_m_ready)
   );

   assign s_axis_tready   = fifo_s_ready & ~sync_reset;
   assign s_status_tready = (exp_cnt_reg != (EXP_AW+1)'(EXP_DEPTH)) & ~sync_reset;
   assign in_take         = s_axis_tvalid & s_axis_tready;
   assign exp_push        = s_status_tvalid & s_status_tready;
   assign exp_nonempty    = (exp_cnt_reg != '0);

   // Data is only released while its frame's exponent sits at the head of the exponent FIFO.
   assign m_axis_tvalid = fifo_m_valid & exp_nonempty;
   assign fifo_m_ready  = m_axis_tready & exp_nonempty;
   assign out_take      = m_axis_tvalid & m_axis_tready;
   assign exp_pop       = out_take & m_axis_tlast;

   // Sizes are at least 8, so bin 0 is never the last bin; that keeps both flags off the live fft_size.
   assign in_last      = (in_bin_reg != '0) && ({1'b0, in_bin_reg} == size_reg - 10'd1);
   assign m_axis_tlast = (out_bin_reg != '0) && ({1'b0, out_bin_reg} == out_size_reg - 10'd1);
   assign m_axis_tuser = pack_tuser(exp_mem_reg[exp_rd_ptr_reg], out_bin_reg);
   assign frame_err    = frame_err_reg;

   always_ff @(posedge clk or posedge sync_reset) begin
      if (sync_reset) begin
         in_bin_reg    <= '0;
         size_reg      <= '0;
         frame_err_reg <= 1'b0;
      end else if (in_take) begin
         if (in_bin_reg == '0) size_reg <= fft_size;
         in_bin_reg <= in_last ? '0 : in_bin_reg + BIN_W'(1);
         if (s_axis_tlast != in_last) frame_err_reg <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge sync_reset) begin
      if (sync_reset) begin
         out_bin_reg  <= '0;
         out_size_reg <= '0;
      end else if (out_take) begin
         if (out_bin_reg == '0) out_size_reg <= fft_size;
         out_bin_reg <= m_axis_tlast ? '0 : out_bin_reg + BIN_W'(1);
      end
   end

   always_ff @(posedge clk or posedge sync_reset) begin
      if (sync_reset) begin
         for (int i = 0; i < EXP_DEPTH; i++) exp_mem_reg[i] <= '0;
         exp_wr_ptr_reg <= '0;
         exp_rd_ptr_reg <= '0;
         exp_cnt_reg    <= '0;
      end else begin
         if (exp_push) begin
            exp_mem_reg[exp_wr_ptr_reg] <= s_status_tdata;
            exp_wr_ptr_reg <= exp_wr_ptr_reg + EXP_AW'(1);
         end
         if (exp_pop) exp_rd_ptr_reg <= exp_rd_ptr_reg + EXP_AW'(1);
         case ({exp_push, exp_pop})
            2'b10:   exp_cnt_reg <= exp_cnt_reg + (EXP_AW+1)'(1);
            2'b01:   exp_cnt_reg <= exp_cnt_reg - (EXP_AW+1)'(1);
            default: exp_cnt_reg <= exp_cnt_reg;
         endcase
      end
   end

endmodule

// File: tb/tb_fft_exp_tagger_512mmax.sv
// Scoreboard bench: frames are modelled per bin at issue time, a monitor checks every output beat.
module tb_fft_exp_tagger_512mmax;

   logic        clk = 1'b0;
   logic        sync_reset;
   logic        s_axis_tvalid, s_axis_tlast, s_axis_tready;
   logic [31:0] s_axis_tdata;
   logic        s_status_tvalid, s_status_tready;
   logic [4:0]  s_status_tdata;
   logic [9:0]  fft_size;
   logic        frame_err;
   logic        m_axis_tvalid, m_axis_tlast, m_axis_tready;
   logic [31:0] m_axis_tdata;
   logic [23:0] m_axis_tuser;

   fft_exp_tagger_512mmax dut (
      .clk             (clk),
      .sync_reset      (sync_reset),
      .s_axis_tvalid   (s_axis_tvalid),
      .s_axis_tdata    (s_axis_tdata),
      .s_axis_tlast    (s_axis_tlast),
      .s_axis_tready   (s_axis_tready),
      .s_status_tvalid (s_status_tvalid),
      .s_status_tdata  (s_status_tdata),
      .s_status_tready (s_status_tready),
      .fft_size        (fft_size),
      .frame_err       (frame_err),
      .m_axis_tvalid   (m_axis_tvalid),
      .m_axis_tdata    (m_axis_tdata),
      .m_axis_tuser    (m_axis_tuser),
      .m_axis_tlast    (m_axis_tlast),
      .m_axis_tready   (m_axis_tready)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] d;
      logic [23:0] u;
      logic        l;
   } beat_t;

   beat_t       sb_q[$];
   logic [31:0] frame_data [512];
   int          checks = 0;
   int          errors = 0;
   int          ready_mode = 0;   // 0: hold low, 1: always high, 2: random

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Downstream ready driver.
   initial begin
      m_axis_tready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0:       m_axis_tready = 1'b0;
            1:       m_axis_tready = 1'b1;
            default: m_axis_tready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Monitor: every accepted output beat is compared against the head of the scoreboard.
   initial begin
      beat_t e;
      forever begin
         @(negedge clk);
         if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_out", {m_axis_tdata, m_axis_tuser, m_axis_tlast}, 64'hDEAD);
            end else begin
               e = sb_q.pop_front();
               chk("out_beat", {7'd0, m_axis_tdata, m_axis_tuser, m_axis_tlast}, {7'd0, e});
               $display("beat bin=%0d exp=%0h tlast=%0b data=%08h", m_axis_tuser[8:0],
                        m_axis_tuser[20:16], m_axis_tlast, m_axis_tdata);
            end
         end
      end
   end

   // Random frame contents; when expected, every bin's beat is queued in natural order.
   task automatic make_frame(input int n, input logic [4:0] e, input bit expect_out);
      beat_t x;
      for (int i = 0; i < n; i++) begin
         frame_data[i] = $urandom;
         if (expect_out) begin
            x.d = frame_data[i];
            x.u = {3'b000, e, 7'b0000000, 9'(i)};
            x.l = (i == n - 1);
            sb_q.push_back(x);
         end
      end
   endtask

   // Called aligned to posedge+1; leaves the bus aligned the same way.
   task automatic drive_samples(input int lo, input int hi, input int last_idx);
      int w;
      for (int i = lo; i < hi; i++) begin
         s_axis_tvalid = 1'b1;
         s_axis_tdata  = frame_data[i];
         s_axis_tlast  = (i == last_idx);
         w = 0;
         @(negedge clk);
         while (!s_axis_tready && w < 5000) begin
            w++;
            @(negedge clk);
         end
         if (!s_axis_tready) begin
            chk("in_timeout", 64'd1, 64'd0);
            s_axis_tvalid = 1'b0;
            return;
         end
         @(posedge clk);
         #1;
      end
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
   endtask

   task automatic send_exp(input logic [4:0] e);
      int w = 0;
      s_status_tvalid = 1'b1;
      s_status_tdata  = e;
      @(negedge clk);
      while (!s_status_tready && w < 5000) begin
         w++;
         @(negedge clk);
      end
      if (!s_status_tready) chk("exp_timeout", 64'd1, 64'd0);
      @(posedge clk);
      #1;
      s_status_tvalid = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int w = 0;
      while (sb_q.size() != 0 && w < 20000) begin
         w++;
         @(negedge clk);
      end
      chk(name, 64'(sb_q.size()), 64'd0);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk({name, "_idle"}, 64'(m_axis_tvalid), 64'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      sync_reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      sync_reset = 1'b0;
      sb_q.delete();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int sizes[5] = '{8, 16, 32, 64, 128};
      logic [4:0] e;
      sync_reset = 1'b1;
      s_axis_tvalid = 1'b0;
      s_axis_tdata = '0;
      s_axis_tlast = 1'b0;
      s_status_tvalid = 1'b0;
      s_status_tdata = '0;
      fft_size = 10'd16;

      // Reset state.
      @(negedge clk);
      chk("reset_m_axis", {m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast}, 64'd0);
      chk("reset_flags", {frame_err, s_axis_tready, s_status_tready}, 64'd0);
      @(posedge clk);
      #1;
      sync_reset = 1'b0;
      @(negedge clk);
      chk("post_reset_ready", {s_axis_tready, s_status_tready}, 64'd3);
      @(posedge clk);
      #1;

      // 1. Frame then exponent -3: held until the exponent arrives.
      ready_mode = 1;
      make_frame(16, 5'h1D, 1'b1);
      drive_samples(0, 16, 15);
      repeat (4) @(negedge clk);
      chk("hold_until_exp", 64'(m_axis_tvalid), 64'd0);
      @(posedge clk);
      #1;
      send_exp(5'(-3));
      wait_drain("basic_frame");

      // 2. Exponent first, 512-sample frame, 2-clk latency of the first sample.
      fft_size = 10'd512;
      send_exp(5'd4);
      make_frame(512, 5'd4, 1'b1);
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = frame_data[0];
      s_axis_tlast  = 1'b0;
      @(posedge clk);
      #1;
      s_axis_tvalid = 1'b0;
      @(negedge clk);
      chk("lat_1clk", 64'(m_axis_tvalid), 64'd0);
      @(negedge clk);
      chk("lat_2clk", 64'(m_axis_tvalid), 64'd1);
      @(posedge clk);
      #1;
      drive_samples(1, 512, 511);
      wait_drain("exp_first");

      // 3. Back-to-back frames of 64, exponents 1,2,3, random downstream ready.
      fft_size = 10'd64;
      ready_mode = 2;
      for (int f = 1; f <= 3; f++) send_exp(5'(f));
      for (int f = 1; f <= 3; f++) begin
         make_frame(64, 5'(f), 1'b1);
         drive_samples(0, 64, 63);
      end
      wait_drain("back_to_back");

      // 4. Backpressure: 1024 samples fill the data FIFO.
      ready_mode = 0;
      fft_size = 10'd512;
      send_exp(5'd7);
      send_exp(5'd9);
      make_frame(512, 5'd7, 1'b1);
      drive_samples(0, 512, 511);
      make_frame(512, 5'd9, 1'b1);
      drive_samples(0, 512, 511);
      @(negedge clk);
      chk("full_after_1024", 64'(s_axis_tready), 64'd0);
      s_axis_tvalid = 1'b1;
      repeat (3) @(negedge clk);
      chk("full_holds", 64'(s_axis_tready), 64'd0);
      s_axis_tvalid = 1'b0;
      @(posedge clk);
      #1;
      ready_mode = 1;
      wait_drain("backpressure");

      // 5. Framing error: tlast on the 6th sample of an 8-bin frame.
      chk("err_clear", 64'(frame_err), 64'd0);
      fft_size = 10'd8;
      send_exp(5'd2);
      make_frame(8, 5'd2, 1'b1);
      drive_samples(0, 8, 5);
      @(negedge clk);
      chk("err_set", 64'(frame_err), 64'd1);
      @(posedge clk);
      #1;
      wait_drain("err_frame");
      send_exp(5'd3);
      make_frame(8, 5'd3, 1'b1);
      drive_samples(0, 8, 7);
      wait_drain("err_next_frame");
      chk("err_sticky", 64'(frame_err), 64'd1);

      // 6. Reset after 5 of 16 samples flushes everything.
      fft_size = 10'd16;
      make_frame(16, 5'd0, 1'b0);
      drive_samples(0, 5, 15);
      pulse_reset();
      @(negedge clk);
      chk("rst_mid_valid", 64'(m_axis_tvalid), 64'd0);
      chk("rst_mid_err", 64'(frame_err), 64'd0);
      @(posedge clk);
      #1;
      send_exp(5'd6);
      make_frame(16, 5'd6, 1'b1);
      drive_samples(0, 16, 15);
      wait_drain("after_reset");

      // 7. Random groups: random size, exponents and exponent-before/after order.
      ready_mode = 2;
      for (int g = 0; g < 3; g++) begin
         fft_size = 10'(sizes[$urandom_range(0, 4)]);
         for (int f = 0; f < 4; f++) begin
            e = 5'($urandom);
            make_frame(int'(fft_size), e, 1'b1);
            if ($urandom_range(0, 1) == 1) begin
               send_exp(e);
               drive_samples(0, int'(fft_size), int'(fft_size) - 1);
            end else begin
               drive_samples(0, int'(fft_size), int'(fft_size) - 1);
               send_exp(e);
            end
         end
         wait_drain("random_group");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
